// File: rtl/mem_arbiter.sv
// Fetch/mem-stage arbiter for one shared single-port memory.
// One transaction in flight; data port wins unless fetch is starving.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IValid,
  output logic        IStall,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  input  logic [3:0]  DStrb,
  output logic [31:0] DRdata,
  output logic        DValid,
  output logic        DStall,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  output logic [3:0]  MemStrb,
  input  logic        MemReady,
  input  logic [31:0] MemRdata
);

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     state;
  state_t     stateNext;
  logic [2:0] starveCnt;
  logic [2:0] starveNext;
  logic       grantI;
  logic       grantD;
  logic       done;

  // Arbitration and completion; no grant while a Valid pulse is out,
  // so a requester that just completed is never granted twice.
  always_comb begin
    stateNext  = state;
    starveNext = starveCnt;
    grantI     = 1'b0;
    grantD     = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!IValid && !DValid) begin
          if (DReq && (!IReq || starveCnt < LIMIT)) begin
            grantD    = 1'b1;
            stateNext = D_BUSY;
            if (!IReq)
              starveNext = 3'd0;
            else if (starveCnt != 3'd7)
              starveNext = starveCnt + 3'd1;
          end else if (IReq) begin
            grantI     = 1'b1;
            stateNext  = I_BUSY;
            starveNext = 3'd0;
          end
        end
      end
      I_BUSY, D_BUSY: begin
        if (MemReady) begin
          done      = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and starvation counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      starveCnt <= 3'd0;
    end else begin
      state     <= stateNext;
      starveCnt <= starveNext;
    end
  end

  // Capture the granted request; memory port is driven only from here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MemWe    <= 1'b0;
      MemAddr  <= 32'd0;
      MemWdata <= 32'd0;
      MemStrb  <= 4'd0;
    end else if (grantD) begin
      MemWe    <= DWe;
      MemAddr  <= DAddr;
      MemWdata <= DWdata;
      MemStrb  <= DStrb;
    end else if (grantI) begin
      MemWe    <= 1'b0;
      MemAddr  <= IAddr;
      MemWdata <= 32'd0;
      MemStrb  <= 4'hF;
    end
  end

  // Completion pulses and returned data, held until the next completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IValid <= 1'b0;
      DValid <= 1'b0;
      IRdata <= 32'd0;
      DRdata <= 32'd0;
    end else begin
      IValid <= done && (state == I_BUSY);
      DValid <= done && (state == D_BUSY);
      if (done && state == I_BUSY)
        IRdata <= MemRdata;
      if (done && state == D_BUSY && !MemWe)
        DRdata <= MemRdata;
    end
  end

  assign MemReq = (state != IDLE);
  assign IStall = IReq & ~IValid;
  assign DStall = DReq & ~DValid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic,
// all compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        IReq;
  logic [31:0] IAddr;
  logic [31:0] IRdata;
  logic        IValid;
  logic        IStall;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAddr;
  logic [31:0] DWdata;
  logic [3:0]  DStrb;
  logic [31:0] DRdata;
  logic        DValid;
  logic        DStall;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [3:0]  MemStrb;
  logic        MemReady;
  logic [31:0] MemRdata;

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata),
    .IValid(IValid), .IStall(IStall),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
    .DStrb(DStrb), .DRdata(DRdata), .DValid(DValid), .DStall(DStall),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWdata(MemWdata), .MemStrb(MemStrb),
    .MemReady(MemReady), .MemRdata(MemRdata)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // reference model: who owns memory (0 none, 1 fetch, 2 data)
  int          owner;
  int          starve;
  logic        tWe;
  logic [31:0] tAddr;
  logic [31:0] tWd;
  logic [3:0]  tStrb;
  logic        mIv;
  logic        mDv;
  logic [31:0] mIr;
  logic [31:0] mDr;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic modelReset();
    owner = 0; starve = 0;
    tWe = 0; tAddr = 0; tWd = 0; tStrb = 0;
    mIv = 0; mDv = 0; mIr = 0; mDr = 0;
  endtask

  // one clock of the arbitration rules applied to current inputs
  task automatic modelStep();
    logic niv;
    logic ndv;
    niv = 0;
    ndv = 0;
    if (!reset) begin
      modelReset();
      return;
    end
    if (owner == 0) begin
      if (!mIv && !mDv) begin
        if (DReq && (!IReq || starve < LIM)) begin
          owner = 2;
          tWe = DWe; tAddr = DAddr; tWd = DWdata; tStrb = DStrb;
          starve = IReq ? ((starve < 7) ? starve + 1 : 7) : 0;
        end else if (IReq) begin
          owner = 1;
          tWe = 0; tAddr = IAddr; tWd = 0; tStrb = 4'hF;
          starve = 0;
        end
      end
    end else if (MemReady) begin
      if (owner == 1) begin
        niv = 1;
        mIr = MemRdata;
      end else begin
        ndv = 1;
        if (!tWe) mDr = MemRdata;
      end
      owner = 0;
    end
    mIv = niv;
    mDv = ndv;
  endtask

  task automatic compareAll();
    check("MemReq", MemReq, owner != 0);
    if (owner != 0) begin
      check("MemWe", MemWe, tWe);
      check("MemAddr", MemAddr, tAddr);
      check("MemWdata", MemWdata, tWd);
      check("MemStrb", MemStrb, tStrb);
    end
    check("IValid", IValid, mIv);
    check("DValid", DValid, mDv);
    check("IRdata", IRdata, mIr);
    check("DRdata", DRdata, mDr);
    check("IStall", IStall, IReq & ~mIv);
    check("DStall", DStall, DReq & ~mDv);
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  initial begin
    int n;
    int dCnt;
    logic iSeen;
    logic prev;
    logic [31:0] drKeep;

    reset = 0; IReq = 0; IAddr = 0; DReq = 0; DWe = 0;
    DAddr = 0; DWdata = 0; DStrb = 0; MemReady = 0; MemRdata = 0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    compareAll();
    check("rst_MemAddr", MemAddr, 32'd0);
    check("rst_MemStrb", MemStrb, 32'd0);
    reset = 1;

    // single fetch, granted on the first edge after reset release
    IReq = 1; IAddr = 32'h100;
    cycle();
    check("fetch_req", MemReq, 1);
    check("fetch_addr", MemAddr, 32'h100);
    MemReady = 1; MemRdata = 32'h0050_0093;
    cycle();
    check("fetch_valid", IValid, 1);
    check("fetch_data", IRdata, 32'h0050_0093);
    IReq = 0; MemReady = 0;
    cycle();
    check("fetch_pulse", IValid, 0);

    // simultaneous: data write first, fetch after
    drKeep = mDr;
    IReq = 1; IAddr = 32'h104;
    DReq = 1; DWe = 1; DAddr = 32'h2000;
    DWdata = 32'hDEAD_BEEF; DStrb = 4'b0011;
    cycle();
    check("sim_strb", MemStrb, 4'b0011);
    check("sim_we", MemWe, 1);
    check("sim_istall", IStall, 1);
    MemReady = 1; MemRdata = 32'hCAFE_0001;
    cycle();
    check("sim_dvalid", DValid, 1);
    check("sim_drkeep", DRdata, drKeep);
    DReq = 0; DWe = 0;
    cycle();
    cycle();
    check("sim_iaddr", MemAddr, 32'h104);
    check("sim_ivalid_pre", IValid, 0);
    cycle();
    check("sim_ivalid", IValid, 1);
    IReq = 0; MemReady = 0;
    cycle();

    // starvation: fetch held, data keeps asking
    IReq = 1; IAddr = 32'h300;
    DReq = 1; DWe = 0; DAddr = 32'h400; DStrb = 4'hF;
    MemReady = 1;
    dCnt = 0; iSeen = 0;
    for (int k = 0; k < 60 && !iSeen; k++) begin
      prev = MemReq;
      MemRdata = $urandom;
      cycle();
      if (MemReq && !prev) begin
        if (MemAddr == 32'h400) dCnt++;
        else if (MemAddr == 32'h300) iSeen = 1;
      end
    end
    check("starve_igrant", iSeen, 1);
    check("starve_dcount", dCnt, LIM);
    DReq = 0;
    cycle();
    IReq = 0; MemReady = 0;
    cycle();
    cycle();

    // wait states on a data read
    DReq = 1; DWe = 0; DAddr = 32'h40; DStrb = 4'hF;
    cycle();
    n = 0;
    for (int k = 0; k < 12 && MemReq; k++) begin
      n++;
      MemReady = (n == 6);
      MemRdata = (n == 6) ? 32'h1234_5678 : $urandom;
      cycle();
    end
    check("ws_cycles", n, 6);
    check("ws_dvalid", DValid, 1);
    check("ws_drdata", DRdata, 32'h1234_5678);
    DReq = 0; MemReady = 0;
    cycle();

    // fetch request held through its Valid cycle
    IReq = 1; IAddr = 32'h500; MemReady = 1;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (MemReq) n++;
    end
    IReq = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (MemReq) n++;
    end
    check("nodup_txns", n, 1);
    MemReady = 0;

    // reset while a fetch is waiting on memory
    IReq = 1; IAddr = 32'h600;
    cycle();
    check("rb_busy", MemReq, 1);
    #3 reset = 0;
    #1;
    modelReset();
    check("rb_memreq", MemReq, 0);
    check("rb_memaddr", MemAddr, 32'd0);
    check("rb_memstrb", MemStrb, 32'd0);
    check("rb_irdata", IRdata, 32'd0);
    check("rb_drdata", DRdata, 32'd0);
    @(posedge clk);
    #1;
    IReq = 0; MemReady = 1; reset = 1;
    cycle();
    cycle();
    check("rb_noivalid", IValid, 0);
    IReq = 1; IAddr = 32'h700;
    cycle();
    check("rb_regrant", MemAddr, 32'h700);
    cycle();
    IReq = 0; MemReady = 0;
    cycle();

    // random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      if (IReq && mIv) begin
        IReq = $urandom_range(0, 1);
        IAddr = $urandom;
      end else if (!IReq && $urandom_range(0, 9) < 3) begin
        IReq = 1;
        IAddr = $urandom;
      end
      if (DReq && mDv) begin
        DReq = $urandom_range(0, 1);
        DWe = $urandom_range(0, 1);
        DAddr = $urandom; DWdata = $urandom; DStrb = 4'($urandom);
      end else if (!DReq && $urandom_range(0, 9) < 4) begin
        DReq = 1;
        DWe = $urandom_range(0, 1);
        DAddr = $urandom; DWdata = $urandom; DStrb = 4'($urandom);
      end
      MemReady = ($urandom_range(0, 2) != 0);
      MemRdata = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
